// File: rtl/tl_pkg.sv
// Shared TileLink definitions: A-channel opcodes and the beat-count helper
// used by the A arbiter and future D/C-channel arbiters.
package tl_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        ArithmeticData = 3'd2,
        LogicalData    = 3'd3,
        Get            = 3'd4,
        Intent         = 3'd5,
        AcquireBlock   = 3'd6,
        AcquirePerm    = 3'd7
    } tl_a_op_e;

    // Opcodes below 4 carry data; only those spread over several beats.
    function automatic int unsigned tl_a_beats(input logic [2:0]  opcode,
                                               input int unsigned size,
                                               input int unsigned lg_mask);
        if (opcode < 3'd4 && size > lg_mask) begin
            return 32'd1 << (size - lg_mask);
        end
        return 32'd1;
    endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping modulo N. Returns both a one-hot grant and its binary index.
module tl_rr_picker #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        logic        found;
        int unsigned c;
        found   = 1'b0;
        c       = 0;
        grant_o = '0;
        idx_o   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c = (32'(ptr_i) + i) % N;
            if (!found && valid_i[c]) begin
                found      = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/tl_a_arbiter.sv
// Round-robin merge of NumHosts TileLink A channels onto one device A channel,
// locking the grant across stalled beats and multi-beat data messages.
//   state | meaning
//   IDLE  | arbitrating among hosts with the round-robin picker
//   HOLD  | offered beat stalled by the device; grant locked to hold_idx_q
//   BURST | mid multi-beat message; cnt_q beats remain for hold_idx_q
module tl_a_arbiter
    import tl_pkg::*;
#(
    parameter  int unsigned NumHosts    = 2,
    parameter  int unsigned SourceWidth = 1,
    parameter  int unsigned AddrWidth   = 56,
    parameter  int unsigned DataWidth   = 64,
    parameter  int unsigned SizeWidth   = 3,
    parameter  int unsigned MaxSize     = 6,
    localparam int unsigned MaskWidth   = DataWidth / 8,
    localparam int unsigned IdxW        = $clog2(NumHosts)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumHosts-1:0]             host_a_valid_i,
    output logic [NumHosts-1:0]             host_a_ready_o,
    input  logic [NumHosts*3-1:0]           host_a_opcode_i,
    input  logic [NumHosts*3-1:0]           host_a_param_i,
    input  logic [NumHosts*SizeWidth-1:0]   host_a_size_i,
    input  logic [NumHosts*SourceWidth-1:0] host_a_source_i,
    input  logic [NumHosts*AddrWidth-1:0]   host_a_address_i,
    input  logic [NumHosts*MaskWidth-1:0]   host_a_mask_i,
    input  logic [NumHosts-1:0]             host_a_corrupt_i,
    input  logic [NumHosts*DataWidth-1:0]   host_a_data_i,
    input  logic                            dev_a_ready_i,
    output logic                            dev_a_valid_o,
    output logic [2:0]                      dev_a_opcode_o,
    output logic [2:0]                      dev_a_param_o,
    output logic [SizeWidth-1:0]            dev_a_size_o,
    output logic [SourceWidth-1:0]          dev_a_source_o,
    output logic [AddrWidth-1:0]            dev_a_address_o,
    output logic [MaskWidth-1:0]            dev_a_mask_o,
    output logic                            dev_a_corrupt_o,
    output logic [DataWidth-1:0]            dev_a_data_o,
    output logic [IdxW-1:0]                 grant_idx_o
);

    localparam int unsigned LgMask = $clog2(MaskWidth);
    localparam int unsigned BeatW  = (MaxSize > LgMask + 1) ? MaxSize - LgMask : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     hold_idx_q, hold_idx_d;
    logic [BeatW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]     pick_idx, sel, rr_next;
    logic [NumHosts-1:0] pick_gnt, sel_oh;
    int unsigned         sel_i, beats;
    logic                sel_valid, fire, single;
    logic [BeatW-1:0]    beats_m1;

    tl_rr_picker #(.N(NumHosts)) u_picker (
        .valid_i (host_a_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_gnt),
        .idx_o   (pick_idx)
    );

    assign sel       = (state_q == IDLE) ? pick_idx : hold_idx_q;
    assign sel_oh    = (state_q == IDLE) ? pick_gnt : (NumHosts'(1) << hold_idx_q);
    assign sel_i     = 32'(sel);
    assign sel_valid = host_a_valid_i[sel_i];
    assign fire      = sel_valid & dev_a_ready_i;
    assign rr_next   = IdxW'((sel_i + 1) % NumHosts);

    assign beats    = tl_a_beats(dev_a_opcode_o, 32'(dev_a_size_o), LgMask);
    assign single   = (beats == 32'd1);
    assign beats_m1 = BeatW'(beats - 32'd1);

    assign dev_a_opcode_o  = host_a_opcode_i[sel_i*3 +: 3];
    assign dev_a_param_o   = host_a_param_i[sel_i*3 +: 3];
    assign dev_a_size_o    = host_a_size_i[sel_i*SizeWidth +: SizeWidth];
    assign dev_a_source_o  = host_a_source_i[sel_i*SourceWidth +: SourceWidth];
    assign dev_a_address_o = host_a_address_i[sel_i*AddrWidth +: AddrWidth];
    assign dev_a_mask_o    = host_a_mask_i[sel_i*MaskWidth +: MaskWidth];
    assign dev_a_corrupt_o = host_a_corrupt_i[sel_i];
    assign dev_a_data_o    = host_a_data_i[sel_i*DataWidth +: DataWidth];

    // Handshake outputs are gated by reset so they drop without a clock edge.
    assign dev_a_valid_o  = rst_ni & sel_valid;
    assign host_a_ready_o = (rst_ni & dev_a_ready_i) ? sel_oh : '0;
    assign grant_idx_o    = rst_ni ? sel : '0;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_idx_d = hold_idx_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    hold_idx_d = sel;
                    if (!dev_a_ready_i) begin
                        state_d = HOLD;
                    end else if (single) begin
                        rr_ptr_d = rr_next;
                    end else begin
                        cnt_d   = beats_m1;
                        state_d = BURST;
                    end
                end
            end
            HOLD: begin
                if (fire) begin
                    if (single) begin
                        rr_ptr_d = rr_next;
                        state_d  = IDLE;
                    end else begin
                        cnt_d   = beats_m1;
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (fire) begin
                    if (cnt_q == BeatW'(1)) begin
                        rr_ptr_d = rr_next;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - BeatW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            hold_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_idx_q <= hold_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    for (genvar h = 0; h < NumHosts; h++) begin : g_size_chk
        a_size_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
            host_a_valid_i[h] |-> (32'(host_a_size_i[h*SizeWidth +: SizeWidth]) <= MaxSize))
            else $error("a_size above MaxSize on host %0d", h);
    end

    a_hold_kept : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == HOLD) |-> sel_valid)
        else $error("stalled A beat retracted by host %0d", hold_idx_q);

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Bench for tl_a_arbiter: directed vector table, multi-cycle corner sequences,
// and random traffic against a message-level reference model.
module tb_tl_a_arbiter;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]     h_valid, h_ready, h_corr;
    logic [N*3-1:0]   h_op, h_param, h_size;
    logic [N-1:0]     h_src;
    logic [N*56-1:0]  h_addr;
    logic [N*8-1:0]   h_mask;
    logic [N*64-1:0]  h_data;
    logic             d_ready, d_valid, d_corr;
    logic [2:0]       d_op, d_param, d_size;
    logic [0:0]       d_src, gi;
    logic [55:0]      d_addr;
    logic [7:0]       d_mask;
    logic [63:0]      d_data;

    tl_a_arbiter u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_a_valid_i(h_valid), .host_a_ready_o(h_ready),
        .host_a_opcode_i(h_op), .host_a_param_i(h_param), .host_a_size_i(h_size),
        .host_a_source_i(h_src), .host_a_address_i(h_addr), .host_a_mask_i(h_mask),
        .host_a_corrupt_i(h_corr), .host_a_data_i(h_data),
        .dev_a_ready_i(d_ready), .dev_a_valid_o(d_valid),
        .dev_a_opcode_o(d_op), .dev_a_param_o(d_param), .dev_a_size_o(d_size),
        .dev_a_source_o(d_src), .dev_a_address_o(d_addr), .dev_a_mask_o(d_mask),
        .dev_a_corrupt_o(d_corr), .dev_a_data_o(d_data), .grant_idx_o(gi)
    );

    // Three-host instance for the pointer wrap-around case.
    logic [2:0]   h3_valid, h3_ready;
    logic         d3_ready, d3_valid, d3_corr;
    logic [2:0]   d3_op, d3_param, d3_size;
    logic [0:0]   d3_src;
    logic [55:0]  d3_addr;
    logic [7:0]   d3_mask;
    logic [63:0]  d3_data;
    logic [1:0]   gi3;

    tl_a_arbiter #(.NumHosts(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .host_a_valid_i(h3_valid), .host_a_ready_o(h3_ready),
        .host_a_opcode_i({3{3'd4}}), .host_a_param_i(9'd0), .host_a_size_i({3{3'd3}}),
        .host_a_source_i(3'd0), .host_a_address_i(168'd0), .host_a_mask_i(24'hFFFFFF),
        .host_a_corrupt_i(3'd0), .host_a_data_i({64'h2222, 64'h1111, 64'h0000}),
        .dev_a_ready_i(d3_ready), .dev_a_valid_o(d3_valid),
        .dev_a_opcode_o(d3_op), .dev_a_param_o(d3_param), .dev_a_size_o(d3_size),
        .dev_a_source_o(d3_src), .dev_a_address_o(d3_addr), .dev_a_mask_o(d3_mask),
        .dev_a_corrupt_o(d3_corr), .dev_a_data_o(d3_data), .grant_idx_o(gi3)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_host(input int k, input logic v, input logic [2:0] op,
                              input logic [2:0] sz, input logic [63:0] d);
        h_valid[k]         = v;
        h_op[k*3 +: 3]     = op;
        h_size[k*3 +: 3]   = sz;
        h_data[k*64 +: 64] = d;
        h_addr[k*56 +: 56] = 56'(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        h_valid  = '0;
        h3_valid = '0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    // Message length from the byte count: data opcodes move 8 bytes per beat.
    function automatic int beats_of(input int op, input int sz);
        int bytes;
        bytes = 1 << sz;
        if (op <= 3 && bytes > 8) return bytes / 8;
        return 1;
    endfunction

    typedef struct {
        logic [1:0] vld;
        logic       rdy;
        logic       edv;
        logic       egi;
        logic [1:0] ehr;
    } vec_t;

    localparam logic [63:0] D0 = 64'hA0A0_0000_0000_0000;
    localparam logic [63:0] D1 = 64'hB1B1_0000_0000_0001;

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rr, owner, mleft, g, c;
        logic exp_dv, rdy, fire;
        logic [N-1:0] hv;
        int   hop [N];
        int   hsz [N];
        int   hleft [N];
        logic [63:0] hdat [N];

        tbl[0] = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00};
        tbl[1] = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b01};
        tbl[2] = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b10};
        tbl[3] = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b01};
        tbl[4] = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b10};
        tbl[5] = '{2'b10, 1'b0, 1'b1, 1'b1, 2'b00};
        tbl[6] = '{2'b11, 1'b0, 1'b1, 1'b1, 2'b00};
        tbl[7] = '{2'b11, 1'b0, 1'b1, 1'b1, 2'b00};
        tbl[8] = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b10};
        tbl[9] = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b01};

        h_valid = '0; h_op = '0; h_param = '0; h_size = '0; h_src = '0;
        h_addr = '0; h_mask = '1; h_corr = '0; h_data = '0; d_ready = 1'b0;
        h3_valid = '0; d3_ready = 1'b1;

        // Reset state, with hosts already requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_host(0, 1'b1, 3'd4, 3'd3, D0);
        drive_host(1, 1'b1, 3'd4, 3'd3, D1);
        d_ready = 1'b1;
        #1;
        check("reset_dev_valid", 64'(d_valid), 64'd0);
        check("reset_host_ready", 64'(h_ready), 64'd0);
        check("reset_grant_idx", 64'(gi), 64'd0);
        @(negedge clk);
        h_valid = '0;
        rst_n   = 1'b1;

        // Directed table: fairness, then a stalled host1 with host0 arriving.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_host(0, tbl[i].vld[0], 3'd4, 3'd3, D0);
            drive_host(1, tbl[i].vld[1], 3'd4, 3'd3, D1);
            d_ready = tbl[i].rdy;
            #1;
            check($sformatf("tbl%0d_dev_valid", i), 64'(d_valid), 64'(tbl[i].edv));
            if (tbl[i].edv) begin
                check($sformatf("tbl%0d_grant", i), 64'(gi), 64'(tbl[i].egi));
                check($sformatf("tbl%0d_host_ready", i), 64'(h_ready), 64'(tbl[i].ehr));
                check($sformatf("tbl%0d_data", i), d_data, tbl[i].egi ? D1 : D0);
            end
        end

        // Burst lock: 8-beat PutFullData from host0 with host1 Get pending.
        do_reset();
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            drive_host(0, 1'b1, 3'd0, 3'd6, 64'hC000 + 64'(b));
            drive_host(1, 1'b1, 3'd4, 3'd3, D1);
            d_ready = 1'b1;
            #1;
            check($sformatf("burst_beat%0d_grant", b), 64'(gi), 64'd0);
            check($sformatf("burst_beat%0d_data", b), d_data, 64'hC000 + 64'(b));
        end
        @(negedge clk);
        h_valid[0] = 1'b0;
        #1;
        check("burst_after_grant", 64'(gi), 64'd1);
        check("burst_after_valid", 64'(d_valid), 64'd1);

        // Mid-burst bubble: 4-beat PutPartialData, host0 idle for two cycles.
        do_reset();
        begin
            logic [5:0] pat;
            int         beat;
            pat  = 6'b110011;
            beat = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                drive_host(0, pat[i], 3'd1, 3'd5, 64'hD000 + 64'(beat));
                drive_host(1, 1'b1, 3'd4, 3'd3, D1);
                d_ready = 1'b1;
                #1;
                if (pat[i]) begin
                    check($sformatf("bubble%0d_grant", i), 64'(gi), 64'd0);
                    beat++;
                end else begin
                    check($sformatf("bubble%0d_dev_valid", i), 64'(d_valid), 64'd0);
                    check($sformatf("bubble%0d_host1_ready", i), 64'(h_ready[1]), 64'd0);
                end
            end
            @(negedge clk);
            h_valid[0] = 1'b0;
            #1;
            check("bubble_after_grant", 64'(gi), 64'd1);
        end

        // Asynchronous reset during beat 3 of 8.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            drive_host(0, 1'b1, 3'd0, 3'd6, 64'hE000 + 64'(b));
            drive_host(1, 1'b1, 3'd4, 3'd3, D1);
            d_ready = 1'b1;
            #1;
            check($sformatf("arst_beat%0d_grant", b), 64'(gi), 64'd0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_dev_valid", 64'(d_valid), 64'd0);
        check("arst_host_ready", 64'(h_ready), 64'd0);
        check("arst_grant_idx", 64'(gi), 64'd0);
        @(negedge clk);
        drive_host(0, 1'b1, 3'd4, 3'd3, D0);
        rst_n = 1'b1;
        #1;
        check("arst_release_grant0", 64'(gi), 64'd0);
        @(negedge clk);
        #1;
        check("arst_release_grant1", 64'(gi), 64'd1);

        // Wrap-around on the three-host instance.
        do_reset();
        d3_ready = 1'b1;
        @(negedge clk); h3_valid = 3'b010; #1;
        check("wrap_h1", 64'(gi3), 64'd1);
        @(negedge clk); h3_valid = 3'b101; #1;
        check("wrap_h2", 64'(gi3), 64'd2);
        @(negedge clk); h3_valid = 3'b101; #1;
        check("wrap_h0", 64'(gi3), 64'd0);
        @(negedge clk); h3_valid = 3'b111; #1;
        check("wrap_ptr_at_1", 64'(gi3), 64'd1);
        check("wrap_data", d3_data, 64'h1111);
        @(negedge clk); h3_valid = 3'b000;

        // Random traffic against a message-level model.
        do_reset();
        rr = 0; owner = -1; mleft = 0;
        hv = '0;
        for (int k = 0; k < N; k++) begin
            hop[k] = 4; hsz[k] = 0; hleft[k] = 0; hdat[k] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (!hv[k] && $urandom_range(0, 2) != 0) begin
                    if (hleft[k] == 0) begin
                        case ($urandom_range(0, 3))
                            0: hop[k] = 0;
                            1: hop[k] = 1;
                            2: hop[k] = 4;
                            default: hop[k] = 5;
                        endcase
                        hsz[k]   = int'($urandom_range(0, 6));
                        hleft[k] = beats_of(hop[k], hsz[k]);
                    end
                    hv[k]   = 1'b1;
                    hdat[k] = {$urandom, $urandom};
                end
                drive_host(k, hv[k], 3'(hop[k]), 3'(hsz[k]), hdat[k]);
            end
            rdy     = ($urandom_range(0, 3) != 0);
            d_ready = rdy;

            g = owner;
            if (owner < 0) begin
                for (int i = 0; i < N; i++) begin
                    c = (rr + i) % N;
                    if (g < 0 && hv[c]) g = c;
                end
            end
            exp_dv = (g >= 0) && hv[g];
            fire   = exp_dv && rdy;
            #1;
            check("rand_dev_valid", 64'(d_valid), 64'(exp_dv));
            if (exp_dv) begin
                check("rand_grant", 64'(gi), 64'(g));
                check("rand_host_ready", 64'(h_ready), rdy ? (64'd1 << g) : 64'd0);
                check("rand_data", d_data, hdat[g]);
                check("rand_addr", 64'(d_addr), 64'(56'(hdat[g])));
                check("rand_size", 64'(d_size), 64'(hsz[g]));
            end
            @(posedge clk);
            if (fire) begin
                hv[g] = 1'b0;
                hleft[g]--;
                if (mleft == 0) mleft = beats_of(hop[g], hsz[g]);
                mleft--;
                if (mleft == 0) begin
                    owner = -1;
                    rr    = (g + 1) % N;
                end else begin
                    owner = g;
                end
            end else if (exp_dv) begin
                owner = g;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
